fifo_decim_reader: RTL and testbench

- Avalon-MM read master that drains the output (read) slave of the decimation FIFO.
- Keeps one word out of every decim_ratio words and presents the kept words on a valid/ready stream to the downstream DSP/packetiser.
- Runs in the FIFO read-side clock domain; no CDC inside.

---
 rtl/fifo_decim_reader.sv | 148 ++++++++++++++
 tb/tb_fifo_decim_reader.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_decim_reader.sv
// Avalon-MM read master that drains the decimation FIFO and forwards 1 of every decim_ratio words.
// Define FIFO_DECIM_ACC_EN for integrate-and-dump (emit the group sum) instead of pick-first.
//
// state | meaning
// IDLE  | not fetching; read low
// READ  | read request held high until the FIFO accepts it
// HOLD  | decimated word presented on out_data/out_valid, waiting for out_ready
module fifo_decim_reader #(
  parameter int DATA_W  = 32,
  parameter int DECIM_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  input  logic               enable,
  input  logic [DECIM_W-1:0] decim_ratio,
  output logic               fifo_0_out_read,
  input  logic [DATA_W-1:0]  fifo_0_out_readdata,
  input  logic               fifo_0_out_waitrequest,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   rd_count,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [DECIM_W-1:0]   phase_q, phase_d;
  logic [DECIM_W-1:0]   ratio_q, ratio_d;
  logic [CNT_W-1:0]     rd_count_q, rd_count_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;

  logic                 xfer;
  logic                 group_end;
  logic                 emit;
  logic [DECIM_W-1:0]   ratio_eff;
  logic [DATA_W-1:0]    emit_data;

`ifdef FIFO_DECIM_ACC_EN
  logic [DATA_W-1:0]    acc_q, acc_d;
  logic [DATA_W-1:0]    acc_sum;
`endif

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    ratio_d     = ratio_q;
    rd_count_d  = rd_count_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    xfer = (state_q == READ) && !fifo_0_out_waitrequest;

    // The ratio is sampled only at the first word of a group, so mid-group changes wait for the next one.
    if (phase_q == '0) begin
      ratio_eff = (decim_ratio == '0) ? DECIM_W'(1) : decim_ratio;
    end else begin
      ratio_eff = ratio_q;
    end
    group_end = (phase_q == ratio_eff - DECIM_W'(1));

`ifdef FIFO_DECIM_ACC_EN
    acc_d     = acc_q;
    acc_sum   = (phase_q == '0) ? fifo_0_out_readdata : acc_q + fifo_0_out_readdata;
    emit      = group_end;
    emit_data = acc_sum;
`else
    emit      = (phase_q == '0);
    emit_data = fifo_0_out_readdata;
`endif

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = READ;
        end
      end

      READ: begin
        if (xfer) begin
          rd_count_d = rd_count_q + CNT_W'(1);
          ratio_d    = ratio_eff;
          phase_d    = group_end ? '0 : phase_q + DECIM_W'(1);
`ifdef FIFO_DECIM_ACC_EN
          acc_d      = acc_sum;
`endif
          if (emit) begin
            out_data_d  = emit_data;
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end else if (!enable) begin
            state_d = IDLE;
          end
        end
      end

      HOLD: begin
        // No read is issued here; the FIFO fills and back-pressures its writer instead of losing data.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = enable ? READ : IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      ratio_q     <= '0;
      rd_count_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef FIFO_DECIM_ACC_EN
      acc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      ratio_q     <= ratio_d;
      rd_count_q  <= rd_count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
`ifdef FIFO_DECIM_ACC_EN
      acc_q       <= acc_d;
`endif
    end
  end

  assign fifo_0_out_read = (state_q == READ);
  assign busy            = (state_q != IDLE);
  assign out_data        = out_data_q;
  assign out_valid       = out_valid_q;
  assign rd_count        = rd_count_q;

endmodule

// File: tb/tb_fifo_decim_reader.sv
// Directed bench for fifo_decim_reader: a FIFO model serves incrementing words, emitted words are collected.
// Expected values follow FIFO_DECIM_ACC_EN when it is defined for the build.
module tb_fifo_decim_reader;
  localparam int DATA_W  = 32;
  localparam int DECIM_W = 8;
  localparam int CNT_W   = 4;

  logic               clk_clk = 1'b0;
  logic               reset_reset;
  logic               enable;
  logic [DECIM_W-1:0] decim_ratio;
  logic               fifo_0_out_read;
  logic [DATA_W-1:0]  fifo_0_out_readdata;
  logic               fifo_0_out_waitrequest;
  logic [DATA_W-1:0]  out_data;
  logic               out_valid;
  logic               out_ready;
  logic [CNT_W-1:0]   rd_count;
  logic               busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] rd_ptr = '0;
  logic [31:0] avail  = '0;
  logic [31:0] cyc    = '0;
  logic [31:0] outq[$];

  fifo_decim_reader #(.DATA_W(DATA_W), .DECIM_W(DECIM_W), .CNT_W(CNT_W)) dut (
    .clk_clk                (clk_clk),
    .reset_reset            (reset_reset),
    .enable                 (enable),
    .decim_ratio            (decim_ratio),
    .fifo_0_out_read        (fifo_0_out_read),
    .fifo_0_out_readdata    (fifo_0_out_readdata),
    .fifo_0_out_waitrequest (fifo_0_out_waitrequest),
    .out_data               (out_data),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .rd_count               (rd_count),
    .busy                   (busy)
  );

  always #5 clk_clk = ~clk_clk;

  // FIFO model: word n has value n; while stalled the data bus carries junk.
  assign fifo_0_out_waitrequest = (rd_ptr >= avail);
  assign fifo_0_out_readdata    = fifo_0_out_waitrequest ? (32'hDEAD_0000 + cyc) : rd_ptr;

  always @(posedge clk_clk) begin
    cyc <= cyc + 1;
    if (reset_reset) rd_ptr <= '0;
    else if (fifo_0_out_read && !fifo_0_out_waitrequest) rd_ptr <= rd_ptr + 1;
  end

  always @(negedge clk_clk) begin
    if (!reset_reset && out_valid && out_ready) outq.push_back(out_data);
  end

  task automatic do_reset();
    @(negedge clk_clk);
    reset_reset = 1'b1;
    enable      = 1'b0;
    out_ready   = 1'b0;
    avail       = '0;
    @(negedge clk_clk);
    reset_reset = 1'b0;
    outq.delete();
  endtask

  task automatic wait_cnt(input logic [31:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_clk);
      if (rd_ptr >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_clk);
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    do_reset();
    decim_ratio = 8'd1;
    out_ready   = 1'b1;
    avail       = 32'd2;
    enable      = 1'b1;
    wait_cnt(2, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL reset_setup_timeout: got rd_ptr=%0d expected 2", rd_ptr); end
    repeat (3) @(negedge clk_clk);
    total++;
    if (fifo_0_out_read !== 1'b1 || rd_count !== 4'd2 || out_data !== 32'd1) begin
      bad++;
      $display("FAIL reset_pre: got read=%b rd_count=%0d out_data=%0d expected 1 2 1", fifo_0_out_read, rd_count, out_data);
    end
    reset_reset = 1'b1;
    @(negedge clk_clk);
    total++;
    if (fifo_0_out_read !== 1'b0) begin bad++; $display("FAIL reset_read: got %b expected 0", fifo_0_out_read); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    total++;
    if (rd_count !== 4'd0) begin bad++; $display("FAIL reset_rd_count: got %0d expected 0", rd_count); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++;
    if (out_data !== 32'd0) begin bad++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
    reset_reset = 1'b0;
    enable      = 1'b0;
  endtask

  task automatic test_decim4();
    bit ok;
    logic [31:0] exp_q[$];
`ifdef FIFO_DECIM_ACC_EN
    exp_q = '{32'd6, 32'd22, 32'd38};
`else
    exp_q = '{32'd0, 32'd4, 32'd8};
`endif
    do_reset();
    decim_ratio = 8'd4;
    out_ready   = 1'b1;
    avail       = 32'd12;
    enable      = 1'b1;
    wait_cnt(12, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL decim4_timeout: got rd_ptr=%0d expected 12", rd_ptr); end
    repeat (4) @(negedge clk_clk);
    total++;
    if (rd_count !== 4'd12) begin bad++; $display("FAIL decim4_rd_count: got %0d expected 12", rd_count); end
    total++;
    if (outq.size() != exp_q.size()) begin
      bad++;
      $display("FAIL decim4_count: got %0d words expected %0d", outq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < outq.size(); i++) begin
      total++;
      if (outq[i] !== exp_q[i]) begin bad++; $display("FAIL decim4_word%0d: got %0d expected %0d", i, outq[i], exp_q[i]); end
    end
  endtask

  task automatic test_waitrequest();
    do_reset();
    decim_ratio = 8'd1;
    out_ready   = 1'b0;
    avail       = '0;
    enable      = 1'b1;
    @(negedge clk_clk);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (fifo_0_out_read !== 1'b1 || rd_count !== 4'd0 || fifo_0_out_waitrequest !== 1'b1) begin
        bad++;
        $display("FAIL wait_hold%0d: got read=%b rd_count=%0d expected read=1 rd_count=0", i, fifo_0_out_read, rd_count);
      end
      if (i < 4) @(negedge clk_clk);
    end
    avail = 32'd1;
    @(negedge clk_clk);
    total++;
    if (rd_count !== 4'd1) begin bad++; $display("FAIL wait_rd_count: got %0d expected 1", rd_count); end
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'd0) begin
      bad++;
      $display("FAIL wait_capture: got valid=%b data=%h expected valid=1 data=0", out_valid, out_data);
    end
    total++;
    if (fifo_0_out_read !== 1'b0) begin bad++; $display("FAIL wait_read_drop: got %b expected 0", fifo_0_out_read); end
  endtask

  task automatic test_hold();
    bit ok;
    do_reset();
    decim_ratio = 8'd1;
    out_ready   = 1'b0;
    avail       = 32'd8;
    enable      = 1'b1;
    wait_valid(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL hold_timeout: got out_valid=%b expected 1", out_valid); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'd0 || fifo_0_out_read !== 1'b0) begin
        bad++;
        $display("FAIL hold_stable%0d: got valid=%b data=%0d read=%b expected 1 0 0", i, out_valid, out_data, fifo_0_out_read);
      end
      if (i < 2) @(negedge clk_clk);
    end
    out_ready = 1'b1;
    @(negedge clk_clk);
    total++;
    if (fifo_0_out_read !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold_release: got read=%b valid=%b expected 1 0", fifo_0_out_read, out_valid);
    end
    out_ready = 1'b0;
    @(negedge clk_clk);
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'd1 || rd_count !== 4'd2) begin
      bad++;
      $display("FAIL hold_next: got valid=%b data=%0d rd_count=%0d expected 1 1 2", out_valid, out_data, rd_count);
    end
  endtask

  task automatic test_ratio_change();
    bit ok;
    logic [31:0] exp_q[$];
`ifdef FIFO_DECIM_ACC_EN
    exp_q = '{32'd3, 32'd7, 32'd11};
`else
    exp_q = '{32'd0, 32'd3, 32'd5, 32'd7};
`endif
    do_reset();
    decim_ratio = 8'd3;
    out_ready   = 1'b1;
    avail       = 32'd8;
    enable      = 1'b1;
    wait_cnt(2, ok);
    decim_ratio = 8'd2;
    wait_cnt(8, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL ratio_change_timeout: got rd_ptr=%0d expected 8", rd_ptr); end
    repeat (3) @(negedge clk_clk);
    total++;
    if (outq.size() != exp_q.size()) begin
      bad++;
      $display("FAIL ratio_change_count: got %0d words expected %0d", outq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < outq.size(); i++) begin
      total++;
      if (outq[i] !== exp_q[i]) begin bad++; $display("FAIL ratio_change_word%0d: got %0d expected %0d", i, outq[i], exp_q[i]); end
    end
  endtask

  task automatic test_ratio_zero();
    bit ok;
    do_reset();
    decim_ratio = 8'd0;
    out_ready   = 1'b1;
    avail       = 32'd3;
    enable      = 1'b1;
    wait_cnt(3, ok);
    repeat (3) @(negedge clk_clk);
    total++;
    if (!ok || rd_count !== 4'd3) begin bad++; $display("FAIL ratio0_rd_count: got %0d expected 3", rd_count); end
    total++;
    if (outq.size() != 3) begin
      bad++;
      $display("FAIL ratio0_count: got %0d words expected 3", outq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (outq[i] !== 32'(i)) begin bad++; $display("FAIL ratio0_word%0d: got %0d expected %0d", i, outq[i], i); end
      end
    end
  endtask

  task automatic test_enable_resume();
    bit ok;
    int exp_pre;
    logic [CNT_W-1:0] exp_cnt;
    logic [31:0] exp_data;
`ifdef FIFO_DECIM_ACC_EN
    exp_pre  = 0;
    exp_cnt  = 4'd4;
    exp_data = 32'd6;
`else
    exp_pre  = 1;
    exp_cnt  = 4'd5;
    exp_data = 32'd4;
`endif
    do_reset();
    decim_ratio = 8'd4;
    out_ready   = 1'b1;
    avail       = 32'd1;
    enable      = 1'b1;
    wait_cnt(1, ok);
    repeat (3) @(negedge clk_clk);
    total++;
    if (fifo_0_out_read !== 1'b1) begin bad++; $display("FAIL resume_pending: got read=%b expected 1", fifo_0_out_read); end
    enable = 1'b0;
    avail  = 32'd2;
    repeat (3) @(negedge clk_clk);
    total++;
    if (busy !== 1'b0 || rd_count !== 4'd2 || fifo_0_out_read !== 1'b0) begin
      bad++;
      $display("FAIL resume_stop: got busy=%b rd_count=%0d read=%b expected 0 2 0", busy, rd_count, fifo_0_out_read);
    end
    total++;
    if (outq.size() != exp_pre) begin bad++; $display("FAIL resume_pre_words: got %0d expected %0d", outq.size(), exp_pre); end
    outq.delete();
    out_ready = 1'b0;
    avail     = 32'd20;
    enable    = 1'b1;
    wait_valid(ok);
    total++;
    if (!ok || rd_count !== exp_cnt || out_data !== exp_data) begin
      bad++;
      $display("FAIL resume_emit: got rd_count=%0d data=%0d expected %0d %0d", rd_count, out_data, exp_cnt, exp_data);
    end
    out_ready = 1'b1;
    enable    = 1'b0;
  endtask

  task automatic test_wrap();
    bit ok;
    logic [31:0] exp_last;
`ifdef FIFO_DECIM_ACC_EN
    exp_last = 32'd33;
`else
    exp_last = 32'd16;
`endif
    do_reset();
    decim_ratio = 8'd2;
    out_ready   = 1'b1;
    avail       = 32'd18;
    enable      = 1'b1;
    wait_cnt(18, ok);
    repeat (3) @(negedge clk_clk);
    total++;
    if (!ok || rd_count !== 4'd2) begin bad++; $display("FAIL wrap_rd_count: got %0d expected 2", rd_count); end
    total++;
    if (outq.size() != 9) begin
      bad++;
      $display("FAIL wrap_count: got %0d words expected 9", outq.size());
    end else begin
      total++;
      if (outq[8] !== exp_last) begin bad++; $display("FAIL wrap_last: got %0d expected %0d", outq[8], exp_last); end
    end
  endtask

  initial begin
    reset_reset = 1'b1;
    enable      = 1'b0;
    decim_ratio = 8'd1;
    out_ready   = 1'b0;
    repeat (2) @(negedge clk_clk);
    test_reset();
    test_decim4();
    test_waitrequest();
    test_hold();
    test_ratio_change();
    test_ratio_zero();
    test_enable_resume();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
